// File: rtl/func_latency_stats.sv
// Per-frame latency statistics: channel filter, window accumulators (count/sum/min/max/over)
// and a coherent snapshot register bank loaded on request.
module func_latency_stats #(
    parameter int CHANNEL_WIDTH = 9,
    parameter int LAT_WIDTH     = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     func_latency_valid,
    input  logic [47:0]              func_latency_data,
    input  logic                     cfg_chan_filter_en,
    input  logic [CHANNEL_WIDTH-1:0] cfg_chan_filter,
    input  logic [LAT_WIDTH-1:0]     cfg_threshold,
    input  logic                     cfg_clr_on_snap,
    input  logic                     snap_req,
    output logic                     snap_ack,
    output logic [31:0]              stat_count,
    output logic [47:0]              stat_sum,
    output logic [LAT_WIDTH-1:0]     stat_min,
    output logic [LAT_WIDTH-1:0]     stat_max,
    output logic [31:0]              stat_over,
    output logic                     stat_sat
);

    localparam logic [31:0]          CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [47:0]          SUM_MAX  = 48'hFFFF_FFFF_FFFF;
    localparam logic [LAT_WIDTH-1:0] LAT_ONES = {LAT_WIDTH{1'b1}};
    localparam logic [LAT_WIDTH-1:0] LAT_ZERO = {LAT_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } acc_state_e;

    logic [CHANNEL_WIDTH-1:0] chan_s;
    logic [LAT_WIDTH-1:0]     lat_in_s;
    logic                     chan_match_s;
    logic                     unused_data_s;

    logic                     s1_valid_q;
    logic [LAT_WIDTH-1:0]     s1_lat_q;
    logic                     s1_over_q;

    acc_state_e               state_q, state_d, cmt_state_s;
    logic [31:0]              count_q, count_d, cmt_count_s;
    logic [47:0]              sum_q, sum_d, cmt_sum_s;
    logic [48:0]              sum_wide_s;
    logic [LAT_WIDTH-1:0]     min_q, min_d, cmt_min_s;
    logic [LAT_WIDTH-1:0]     max_q, max_d, cmt_max_s;
    logic [31:0]              over_q, over_d, cmt_over_s;
    logic                     sat_q, sat_d, cmt_sat_s;

    logic                     ack_q, ack_d;
    logic [31:0]              snap_count_q, snap_count_d;
    logic [47:0]              snap_sum_q, snap_sum_d;
    logic [LAT_WIDTH-1:0]     snap_min_q, snap_min_d;
    logic [LAT_WIDTH-1:0]     snap_max_q, snap_max_d;
    logic [31:0]              snap_over_q, snap_over_d;
    logic                     snap_sat_q, snap_sat_d;

    assign chan_s        = func_latency_data[32 +: CHANNEL_WIDTH];
    assign lat_in_s      = func_latency_data[LAT_WIDTH-1:0];
    assign chan_match_s  = !cfg_chan_filter_en || (chan_s == cfg_chan_filter);
    assign unused_data_s = ^func_latency_data;

    // Stage 1: qualify the strobe and pre-compute the threshold compare with current config
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_lat_q   <= LAT_ZERO;
            s1_over_q  <= 1'b0;
        end else begin
            s1_valid_q <= func_latency_valid && chan_match_s;
            s1_lat_q   <= lat_in_s;
            s1_over_q  <= (lat_in_s > cfg_threshold);
        end
    end

    // Commit values: accumulators after folding in the stage-1 sample, before any clear
    always_comb begin
        cmt_state_s = state_q;
        cmt_count_s = count_q;
        cmt_sum_s   = sum_q;
        cmt_min_s   = min_q;
        cmt_max_s   = max_q;
        cmt_over_s  = over_q;
        cmt_sat_s   = sat_q;
        sum_wide_s  = {1'b0, sum_q} + {{(49-LAT_WIDTH){1'b0}}, s1_lat_q};
        if (s1_valid_q) begin
            cmt_state_s = ST_ACTIVE;
            if (count_q == CNT_MAX) begin
                cmt_sat_s = 1'b1;
            end else begin
                cmt_count_s = count_q + 32'd1;
            end
            if (sum_wide_s[48]) begin
                cmt_sum_s = SUM_MAX;
                cmt_sat_s = 1'b1;
            end else begin
                cmt_sum_s = sum_wide_s[47:0];
            end
            if (s1_over_q && (over_q == CNT_MAX)) begin
                cmt_sat_s = 1'b1;
            end else if (s1_over_q) begin
                cmt_over_s = over_q + 32'd1;
            end else begin
                cmt_over_s = over_q;
            end
            case (state_q)
                ST_EMPTY: begin
                    cmt_min_s = s1_lat_q;
                    cmt_max_s = s1_lat_q;
                end
                ST_ACTIVE: begin
                    cmt_min_s = (s1_lat_q < min_q) ? s1_lat_q : min_q;
                    cmt_max_s = (s1_lat_q > max_q) ? s1_lat_q : max_q;
                end
                default: begin
                    cmt_min_s = s1_lat_q;
                    cmt_max_s = s1_lat_q;
                end
            endcase
        end else begin
            cmt_state_s = state_q;
        end
    end

    // Next state: optional clear on snapshot, and snapshot bank load from commit values
    always_comb begin
        state_d      = cmt_state_s;
        count_d      = cmt_count_s;
        sum_d        = cmt_sum_s;
        min_d        = cmt_min_s;
        max_d        = cmt_max_s;
        over_d       = cmt_over_s;
        sat_d        = cmt_sat_s;
        ack_d        = snap_req;
        snap_count_d = snap_count_q;
        snap_sum_d   = snap_sum_q;
        snap_min_d   = snap_min_q;
        snap_max_d   = snap_max_q;
        snap_over_d  = snap_over_q;
        snap_sat_d   = snap_sat_q;
        if (snap_req) begin
            snap_count_d = cmt_count_s;
            snap_sum_d   = cmt_sum_s;
            snap_min_d   = (cmt_count_s == 32'd0) ? LAT_ZERO : cmt_min_s;
            snap_max_d   = (cmt_count_s == 32'd0) ? LAT_ZERO : cmt_max_s;
            snap_over_d  = cmt_over_s;
            snap_sat_d   = cmt_sat_s;
        end else begin
            ack_d = 1'b0;
        end
        if (snap_req && cfg_clr_on_snap) begin
            state_d = ST_EMPTY;
            count_d = 32'd0;
            sum_d   = 48'd0;
            min_d   = LAT_ONES;
            max_d   = LAT_ZERO;
            over_d  = 32'd0;
            sat_d   = 1'b0;
        end else begin
            state_d = cmt_state_s;
        end
    end

    // Accumulator and snapshot registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= ST_EMPTY;
            count_q      <= 32'd0;
            sum_q        <= 48'd0;
            min_q        <= LAT_ONES;
            max_q        <= LAT_ZERO;
            over_q       <= 32'd0;
            sat_q        <= 1'b0;
            ack_q        <= 1'b0;
            snap_count_q <= 32'd0;
            snap_sum_q   <= 48'd0;
            snap_min_q   <= LAT_ZERO;
            snap_max_q   <= LAT_ZERO;
            snap_over_q  <= 32'd0;
            snap_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            min_q        <= min_d;
            max_q        <= max_d;
            over_q       <= over_d;
            sat_q        <= sat_d;
            ack_q        <= ack_d;
            snap_count_q <= snap_count_d;
            snap_sum_q   <= snap_sum_d;
            snap_min_q   <= snap_min_d;
            snap_max_q   <= snap_max_d;
            snap_over_q  <= snap_over_d;
            snap_sat_q   <= snap_sat_d;
        end
    end

    assign snap_ack   = ack_q;
    assign stat_count = snap_count_q;
    assign stat_sum   = snap_sum_q;
    assign stat_min   = snap_min_q;
    assign stat_max   = snap_max_q;
    assign stat_over  = snap_over_q;
    assign stat_sat   = snap_sat_q;

endmodule
